// File: rtl/fetch_unit.sv
// fetch_unit -- sequential instruction fetch front end.
//
// Issues one memory read per cycle while running, captures the response one
// cycle later into a 2-entry instruction buffer, and presents the oldest
// buffered instruction to the consumer with a valid/ready handshake. A
// redirect pulse reloads the PC and flushes both the buffer and any
// response still in flight.
//
// Ports
//   i_clk           clock, all state changes on the rising edge
//   i_rst_n         asynchronous active-low reset
//   i_en            run request (high = fetch sequentially)
//   i_redirect      one-cycle pulse: load PC from i_redirect_pc and flush
//   i_redirect_pc   redirect target address
//   o_mem_cs        memory read strobe, one read per asserted cycle
//   o_mem_address   read address (current PC)
//   i_mem_data      read data, valid the cycle after the matching strobe
//   o_instr_valid   head instruction valid
//   i_instr_ready   consumer accepts the head instruction this cycle
//   o_instr         head instruction word
//   o_instr_pc      address the head instruction was fetched from

module fetch_unit #(
  parameter int unsigned addr  = 4,
  parameter int unsigned width = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_redirect,
  input  logic [addr-1:0]  i_redirect_pc,
  output logic             o_mem_cs,
  output logic [addr-1:0]  o_mem_address,
  input  logic [width-1:0] i_mem_data,
  output logic             o_instr_valid,
  input  logic             i_instr_ready,
  output logic [width-1:0] o_instr,
  output logic [addr-1:0]  o_instr_pc
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [addr-1:0]  r_pc;
  logic             r_inflight;
  logic [addr-1:0]  r_inflight_pc;
  logic [1:0]       r_count;
  logic [width-1:0] r_instr0;
  logic [width-1:0] r_instr1;
  logic [addr-1:0]  r_ipc0;
  logic [addr-1:0]  r_ipc1;

  logic             w_pop;
  logic             w_push;
  logic             w_issue;
  logic [2:0]       w_occupancy;
  logic [1:0]       w_count_next;
  logic [width-1:0] w_instr0_next;
  logic [width-1:0] w_instr1_next;
  logic [addr-1:0]  w_ipc0_next;
  logic [addr-1:0]  w_ipc1_next;

  assign o_instr_valid = (r_count != 2'd0);
  assign o_instr       = r_instr0;
  assign o_instr_pc    = r_ipc0;
  assign o_mem_address = r_pc;

  assign w_pop = o_instr_valid & i_instr_ready;

  // Slots committed after this edge: buffered + landing response - leaving
  // head. Issuing only while this is below 2 keeps the buffer from overflowing.
  assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue     = (r_state == ST_RUN) & ~i_redirect & (w_occupancy < 3'd2);
  assign o_mem_cs    = w_issue;

  // A response arriving during a redirect belongs to the old stream: drop it.
  assign w_push = r_inflight & ~i_redirect;

  // Buffer next state; entry 0 is always the head.
  always_comb begin
    w_count_next  = r_count;
    w_instr0_next = r_instr0;
    w_instr1_next = r_instr1;
    w_ipc0_next   = r_ipc0;
    w_ipc1_next   = r_ipc1;
    if (i_redirect) begin
      w_count_next = 2'd0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            w_instr0_next = i_mem_data;
            w_ipc0_next   = r_inflight_pc;
          end else begin
            w_instr1_next = i_mem_data;
            w_ipc1_next   = r_inflight_pc;
          end
          w_count_next = r_count + 2'd1;
        end
        2'b01: begin
          w_instr0_next = r_instr1;
          w_ipc0_next   = r_ipc1;
          w_count_next  = r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            w_instr0_next = i_mem_data;
            w_ipc0_next   = r_inflight_pc;
          end else begin
            w_instr0_next = r_instr1;
            w_ipc0_next   = r_ipc1;
            w_instr1_next = i_mem_data;
            w_ipc1_next   = r_inflight_pc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_count       <= 2'd0;
      r_instr0      <= '0;
      r_instr1      <= '0;
      r_ipc0        <= '0;
      r_ipc1        <= '0;
    end else begin
      r_state <= i_en ? ST_RUN : ST_IDLE;

      if (i_redirect) begin
        r_pc <= i_redirect_pc;
      end else if (w_issue) begin
        r_pc <= r_pc + addr'(1);
      end

      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
      end

      r_count  <= w_count_next;
      r_instr0 <= w_instr0_next;
      r_instr1 <= w_instr1_next;
      r_ipc0   <= w_ipc0_next;
      r_ipc1   <= w_ipc1_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A behavioural model (queue of fetched
// addresses, plain PC counter) predicts every output each cycle; directed
// scenarios add literal expectations on top.

module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       redirect;
  logic [3:0] rpc;
  logic       cs;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic       valid;
  logic       ready;
  logic [7:0] instr;
  logic [3:0] instr_pc;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state.
  bit m_run;
  bit m_infl;
  int m_pc;
  int m_ipc;
  int m_q[$];

  fetch_unit #(.addr(4), .width(8)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .i_redirect   (redirect),
    .i_redirect_pc(rpc),
    .o_mem_cs     (cs),
    .o_mem_address(mem_addr),
    .i_mem_data   (mem_data),
    .o_instr_valid(valid),
    .i_instr_ready(ready),
    .o_instr      (instr),
    .o_instr_pc   (instr_pc)
  );

  always #5 clk = ~clk;

  // 1-cycle synchronous memory, mem[i] = 8'h10 + i.
  always @(posedge clk) begin
    if (cs) mem_data <= 8'h10 + {4'h0, mem_addr};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  function automatic void model_reset();
    m_run  = 1'b0;
    m_infl = 1'b0;
    m_pc   = 0;
    m_ipc  = 0;
    m_q.delete();
  endfunction

  function automatic bit model_cs();
    int sz  = m_q.size();
    int pop = (sz != 0 && ready) ? 1 : 0;
    return m_run && !redirect && (sz + int'(m_infl) - pop) < 2;
  endfunction

  function automatic logic [17:0] exp_vec();
    int         sz = m_q.size();
    logic [3:0] p;
    logic [7:0] w;
    p = (sz != 0) ? 4'(m_q[0]) : 4'h0;
    w = (sz != 0) ? 8'h10 + {4'h0, p} : 8'h00;
    return {model_cs(), 4'(m_pc), sz != 0, w, p};
  endfunction

  function automatic logic [17:0] obs_vec();
    return {cs, mem_addr, valid, valid ? instr : 8'h00, valid ? instr_pc : 4'h0};
  endfunction

  task automatic drive(input bit e, input bit r, input bit d, input int p);
    en       = e;
    ready    = r;
    redirect = d;
    rpc      = 4'(p);
  endtask

  // Advance one clock and move the model across the same edge.
  task automatic tick();
    bit c;
    bit pop;
    c   = model_cs();
    pop = (m_q.size() != 0) && ready;
    @(posedge clk);
    if (redirect) begin
      m_q.delete();
      m_infl = 1'b0;
      m_pc   = int'(rpc);
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(m_ipc);
      if (c) begin
        m_ipc = m_pc;
        m_pc  = (m_pc + 1) % 16;
      end
      m_infl = c;
    end
    m_run = en;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 1, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({cs, mem_addr, valid, instr, instr_pc} !== 18'h0) begin
      n_errors++;
      $display("FAIL reset_outputs got=%h want=%h", {cs, mem_addr, valid, instr, instr_pc}, 18'h0);
    end
    drive(0, 0, 0, 0);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_sequential();
    int k = 0;
    for (int c = 0; c < 24; c++) begin
      drive(1, 1, 0, 0);
      #1;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL seq_model c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      if (c < 2) begin
        n_checks++;
        if (cs !== (c == 1) || mem_addr !== 4'h0) begin
          n_errors++;
          $display("FAIL seq_first_issue c=%0d got cs=%b addr=%h want cs=%b addr=0",
                   c, cs, mem_addr, c == 1);
        end
      end
      if (c < 3) begin
        n_checks++;
        if (valid !== 1'b0) begin
          n_errors++;
          $display("FAIL seq_latency c=%0d got valid=%b want 0", c, valid);
        end
      end else begin
        logic [3:0] kp;
        kp = 4'(k);
        n_checks++;
        if (valid !== 1'b1 || instr !== 8'h10 + {4'h0, kp} || instr_pc !== kp) begin
          n_errors++;
          $display("FAIL seq_stream c=%0d got v=%b i=%h pc=%h want v=1 i=%h pc=%h",
                   c, valid, instr, instr_pc, 8'h10 + {4'h0, kp}, kp);
        end
        k++;
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [3:0] pcs[40];
    logic [7:0] ins[40];
    bit         vld[40];
    int         at = -1;
    for (int c = 0; c < 40; c++) begin
      drive(1, 1, 0, 0);
      #1;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL wrap_model c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      pcs[c] = instr_pc;
      ins[c] = instr;
      vld[c] = valid;
      tick();
    end
    for (int c = 0; c < 36; c++) begin
      if (at < 0 && vld[c] && pcs[c] == 4'd14) at = c;
    end
    n_checks++;
    if (at < 0) begin
      n_errors++;
      $display("FAIL wrap_seen14 got=none want=instr_pc 14 delivered");
    end else begin
      n_checks++;
      if (!(vld[at+1] && vld[at+2] && vld[at+3]) || pcs[at+1] !== 4'd15 || pcs[at+2] !== 4'd0
          || pcs[at+3] !== 4'd1 || ins[at] !== 8'h1E || ins[at+1] !== 8'h1F
          || ins[at+2] !== 8'h10 || ins[at+3] !== 8'h11) begin
        n_errors++;
        $display("FAIL wrap_seq got pc=%h,%h,%h,%h i=%h,%h,%h,%h want pc=e,f,0,1 i=1e,1f,10,11",
                 pcs[at], pcs[at+1], pcs[at+2], pcs[at+3], ins[at], ins[at+1], ins[at+2],
                 ins[at+3]);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] hi;
    logic [3:0] hp;
    hi = instr;
    hp = instr_pc;
    for (int c = 0; c < 5; c++) begin
      drive(1, 0, 0, 0);
      #1;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL stall_model c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      n_checks++;
      if (cs !== 1'b0 || valid !== 1'b1 || instr !== hi || instr_pc !== hp) begin
        n_errors++;
        $display("FAIL stall_hold c=%0d got cs=%b v=%b i=%h pc=%h want cs=0 v=1 i=%h pc=%h",
                 c, cs, valid, instr, instr_pc, hi, hp);
      end
      tick();
    end
    n_checks++;
    if (m_q.size() != 2) begin
      n_errors++;
      $display("FAIL stall_buffered got=%0d want=2", m_q.size());
    end
    for (int c = 0; c < 6; c++) begin
      logic [3:0] ep;
      ep = hp + 4'(c);
      drive(1, 1, 0, 0);
      #1;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL resume_model c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      n_checks++;
      if (valid !== 1'b1 || instr_pc !== ep || instr !== 8'h10 + {4'h0, ep}) begin
        n_errors++;
        $display("FAIL resume_seq c=%0d got v=%b pc=%h i=%h want v=1 pc=%h", c, valid,
                 instr_pc, instr, ep);
      end
      tick();
    end
  endtask

  task automatic test_redirect_inflight();
    int  found = 0;
    bit  got = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      drive(1, 1, 0, 0);
      #1;
      if (cs === 1'b1 && mem_addr === 4'd4) found = 1;
      tick();
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL redir_find4 got=no issue of 4 want=issue of 4 within 40 cycles");
    end
    drive(1, 1, 1, 9);
    #1;
    n_checks++;
    if (cs !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_errors++;
      $display("FAIL redir_cycle got=%h want=%h (cs must be 0)", obs_vec(), exp_vec());
    end
    tick();
    for (int c = 0; c < 6; c++) begin
      drive(1, 1, 0, 0);
      #1;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL redir_model c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      if (valid === 1'b1 && !got) begin
        got = 1;
        n_checks++;
        if (instr_pc !== 4'd9 || instr !== 8'h19) begin
          n_errors++;
          $display("FAIL redir_first got pc=%h i=%h want pc=9 i=19", instr_pc, instr);
        end
      end
      tick();
    end
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL redir_deliver got=nothing want=instr 19 at pc 9");
    end
  endtask

  task automatic test_redirect_pop();
    for (int c = 0; c < 4; c++) begin
      drive(1, 0, 0, 0);
      #1;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL rpop_fill c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      tick();
    end
    n_checks++;
    if (m_q.size() != 2 || valid !== 1'b1) begin
      n_errors++;
      $display("FAIL rpop_two got v=%b model=%0d want v=1 model=2", valid, m_q.size());
    end
    drive(1, 1, 1, 2);
    #1;
    n_checks++;
    if (cs !== 1'b0 || valid !== 1'b1) begin
      n_errors++;
      $display("FAIL rpop_cycle got cs=%b v=%b want cs=0 v=1", cs, valid);
    end
    tick();
    drive(1, 1, 0, 0);
    #1;
    n_checks++;
    if (valid !== 1'b0 || cs !== 1'b1 || mem_addr !== 4'd2) begin
      n_errors++;
      $display("FAIL rpop_after got v=%b cs=%b addr=%h want v=0 cs=1 addr=2", valid, cs,
               mem_addr);
    end
    tick();
  endtask

  task automatic test_idle_redirect();
    int first = -1;
    for (int c = 0; c < 4; c++) begin
      drive(0, 1, 0, 0);
      #1;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL idle_model c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      tick();
    end
    drive(0, 1, 1, 11);
    #1;
    tick();
    for (int c = 0; c < 6; c++) begin
      drive(1, 1, 0, 0);
      #1;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL idle_run c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      if (cs === 1'b1 && first < 0) first = int'(mem_addr);
      tick();
    end
    n_checks++;
    if (first != 11) begin
      n_errors++;
      $display("FAIL idle_redir_addr got=%0d want=11", first);
    end
  endtask

  task automatic test_async_reset();
    int  first_cs = -1;
    bit  got = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1, 1, 0, 0);
      #1;
      tick();
    end
    drive(1, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (cs !== 1'b0 || valid !== 1'b0 || instr !== 8'h0 || instr_pc !== 4'h0
        || mem_addr !== 4'h0) begin
      n_errors++;
      $display("FAIL async_reset got cs=%b v=%b i=%h pc=%h a=%h want all 0", cs, valid, instr,
               instr_pc, mem_addr);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 8; c++) begin
      drive(1, 1, 0, 0);
      #1;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL arst_model c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      if (cs === 1'b1 && first_cs < 0) first_cs = int'(mem_addr);
      if (valid === 1'b1 && !got) begin
        got = 1;
        n_checks++;
        if (instr_pc !== 4'h0 || instr !== 8'h10) begin
          n_errors++;
          $display("FAIL arst_first got pc=%h i=%h want pc=0 i=10", instr_pc, instr);
        end
      end
      tick();
    end
    n_checks++;
    if (first_cs != 0 || !got) begin
      n_errors++;
      $display("FAIL arst_restart got first_addr=%0d delivered=%b want 0 and 1", first_cs, got);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 9) != 0, ($urandom % 3) != 0, $urandom_range(0, 19) == 0,
            int'($urandom_range(0, 15)));
      #1;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL rand_model c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    mem_data = 8'h00;
    drive(0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    test_reset();
    test_sequential();
    test_wrap();
    test_stall();
    test_redirect_inflight();
    test_redirect_pop();
    test_idle_redirect();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: addr, default 4, width of the instruction address and program counter (PC).
REQ-002 Parameter: width, default 8, width of one instruction word.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  run request; high = fetch sequentially, low = stop issuing.
REQ-006 redirect  input  1  one-cycle pulse; load PC from redirect_pc and flush.
REQ-007 redirect_pc  input  addr  target address for redirect.
REQ-008 mem_cs  output  1  memory read strobe; one read per cycle asserted.
REQ-009 mem_address  output  addr  read address, valid when mem_cs=1.
REQ-010 mem_data  input  width  memory read data, valid the cycle after the matching mem_cs.
REQ-011 instr_valid  output  1  instr/instr_pc hold a fetched instruction.
REQ-012 instr_ready  input  1  consumer accepts the instruction this cycle.
REQ-013 instr  output  width  head-of-buffer instruction word.
REQ-014 instr_pc  output  addr  address the head instruction was fetched from.

Function
REQ-015 State machine shall have states IDLE and RUN; IDLE->RUN at the edge where en=1, RUN->IDLE at the edge where en=0; redirect does not change state.
REQ-016 Internal state shall be: pc (addr bits), in-flight flag, and a 2-entry FIFO of {instr, instr_pc} with a count of 0..2.
REQ-017 pop = instr_valid & instr_ready; instr_valid = (count != 0); instr/instr_pc show the oldest entry.
REQ-018 mem_cs shall be combinational: RUN & !redirect & (count + inflight - pop < 2); mem_address = pc.
REQ-019 An issue (mem_cs=1) shall, at the edge, set inflight=1 and advance pc by 1 modulo 2^addr (wrap from 2^addr-1 to 0).
REQ-020 When inflight=1, mem_data shall be pushed into the FIFO at the cycle's ending edge together with the address it was issued from; inflight then clears unless a new issue occurs in that cycle.
REQ-021 Read latency is fixed: issue in cycle N, data sampled in cycle N+1, instr_valid no earlier than cycle N+2.
REQ-022 With instr_ready held high and no redirect, mem_cs shall stay high every RUN cycle (one instruction per cycle sustained).
REQ-023 Push and pop in the same cycle shall leave count unchanged; the FIFO shall never overflow (guaranteed by REQ-018), and an empty FIFO shall never be popped.
REQ-024 On redirect=1 in cycle N: no issue in N; any in-flight response present in N is discarded; FIFO count cleared; pc <= redirect_pc; first issue from redirect_pc in cycle N+1 if RUN.
REQ-025 Redirect and pop in the same cycle: redirect wins; the popped entry counts as consumed, all other entries are flushed.
REQ-026 Redirect while IDLE shall still load pc and flush the FIFO.
REQ-027 en low: no new issues; the in-flight response is still captured; FIFO contents retained and presented until popped.
REQ-028 instr/instr_pc shall hold stable while instr_valid=1 and instr_ready=0.

Reset
REQ-029 While rst_n=0: state=IDLE, pc=0, inflight=0, count=0, mem_cs=0, instr_valid=0; instr and instr_pc read 0.
REQ-030 Reset asserted mid-operation shall take effect immediately without waiting for clk; in-flight data is discarded and fetch restarts from address 0 after en is seen high.

Verification (memory model: 1-cycle synchronous read, mem[i] = 8'h10 + i)
REQ-031 Release reset, en=1, ready=1 -> mem_cs first high one cycle after en sampled, address 0; instr sequence 10,11,12,... with instr_pc 0,1,2, one per cycle after a 2-cycle latency.
REQ-032 Free run past address 15 -> instr_pc 14,15,0,1 with instr 1E,1F,10,11; no bubble at wrap.
REQ-033 ready=0 for 5 cycles during run -> exactly 2 entries buffered, mem_cs low, instr stable; on ready=1 the sequence resumes with no gap or duplicate.
REQ-034 redirect with redirect_pc=9 while a fetch of address 4 is in flight -> 14 never delivered; next instr_valid shows 19 with instr_pc 9.
REQ-035 Assert redirect on the same cycle as a pop with 2 entries buffered -> popped entry consumed, other entry dropped, instr_valid low next cycle.
REQ-036 Pulse rst_n low between clock edges during run -> mem_cs and instr_valid drop immediately; after release, fetch restarts at address 0.
